mips_stepped_core: RTL and testbench

- Multicycle MIPS-subset datapath whose phase is supplied externally on count_state, one phase per clock, by a sequencer or bench.
- Contains PC, instruction memory preloaded with a fixed program, IR, 32-entry register file, A/B/ALUOut registers and ALU.
- Exposes register-file read data and memory read data for observation.
- Top-level block of the CPU; a later UART front end will attach here.

---
 rtl/mips_stepped_core.sv | 175 +++++++++++++++++
 tb/tb_mips_stepped_core.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_stepped_core.sv
// Multicycle MIPS-subset datapath stepped one phase per clock by an external sequencer.
// Ports: clk, reset (sync, active-low), count_state[2:0] phase; RD1/RD2 regfile reads, Mmemory_output ROM read at PC.
module mips_stepped_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NBITS      = 5,
  parameter int Nbit       = 8,
  parameter int baudrate   = 9600,
  parameter int clk_freq   = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            count_state,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] Mmemory_output
);

  // UART settings are carried for the future front end only.
  localparam bit CfgOk = (Nbit > 0) && (baudrate > 0) && (clk_freq > 0);
  if (!CfgOk) begin : g_cfg_bad
  end

  localparam int PCW = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_FETCH  = 3'd1,
    PH_DECODE = 3'd2,
    PH_EXEC   = 3'd3,
    PH_WB     = 3'd4
  } phase_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Fixed program image; unlisted words read as zero.
  function automatic logic [DATA_WIDTH-1:0] rom(
    input logic [ADDR_WIDTH-1:0] idx
  );
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    case (idx)
      ADDR_WIDTH'(0): v = DATA_WIDTH'(32'h2008_0001);
      ADDR_WIDTH'(1): v = DATA_WIDTH'(32'h2009_0002);
      ADDR_WIDTH'(2): v = DATA_WIDTH'(32'h200A_0003);
      ADDR_WIDTH'(3): v = DATA_WIDTH'(32'h200B_00FF);
      ADDR_WIDTH'(4): v = DATA_WIDTH'(32'h218C_0002);
      ADDR_WIDTH'(5): v = DATA_WIDTH'(32'h0128_8820);
      ADDR_WIDTH'(6): v = DATA_WIDTH'(32'h0011_8900);
      ADDR_WIDTH'(7): v = DATA_WIDTH'(32'h022A_8825);
      ADDR_WIDTH'(8): v = DATA_WIDTH'(32'h3173_00F0);
      default:        v = '0;
    endcase
    return v;
  endfunction

  logic [PCW-1:0]        r_pc;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_aluout;
  logic [DATA_WIDTH-1:0] r_rf [32];

  logic [5:0]            w_op;
  logic [5:0]            w_funct;
  logic [4:0]            w_rs;
  logic [4:0]            w_rt;
  logic [4:0]            w_rd;
  logic [NBITS-1:0]      w_shamt;
  logic [DATA_WIDTH-1:0] w_imm_sx;
  logic [DATA_WIDTH-1:0] w_imm_zx;
  logic [ADDR_WIDTH-1:0] w_widx;
  logic [DATA_WIDTH-1:0] w_mem;
  logic [DATA_WIDTH-1:0] w_alu;
  logic                  w_wr_en;
  logic [4:0]            w_wr_addr;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_shamt  = r_ir[6 +: NBITS];
  assign w_funct  = r_ir[5:0];
  assign w_imm_sx = {{(DATA_WIDTH-16){r_ir[15]}}, r_ir[15:0]};
  assign w_imm_zx = {{(DATA_WIDTH-16){1'b0}}, r_ir[15:0]};

  // PC is byte-addressed; the word index wraps with the PC width.
  assign w_widx = r_pc[ADDR_WIDTH+1:2];
  assign w_mem  = rom(w_widx);

  // $0 is never written, so it always reads zero.
  assign RD1            = r_rf[w_rs];
  assign RD2            = r_rf[w_rt];
  assign Mmemory_output = w_mem;

  // IR is stable across execute and writeback, so one decode serves both.
  always_comb begin
    w_alu     = '0;
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    unique case (w_op)
      OP_RTYPE: begin
        w_wr_addr = w_rd;
        w_wr_en   = 1'b1;
        unique case (w_funct)
          FN_ADD: w_alu = r_a + r_b;
          FN_SUB: w_alu = r_a - r_b;
          FN_AND: w_alu = r_a & r_b;
          FN_OR:  w_alu = r_a | r_b;
          FN_SLT: w_alu = {{(DATA_WIDTH-1){1'b0}},
                           ($signed(r_a) < $signed(r_b))};
          FN_SLL: w_alu = r_b << w_shamt;
          FN_SRL: w_alu = r_b >> w_shamt;
          default: w_wr_en = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_alu     = r_a + w_imm_sx;
        w_wr_en   = 1'b1;
        w_wr_addr = w_rt;
      end
      OP_ANDI: begin
        w_alu     = r_a & w_imm_zx;
        w_wr_en   = 1'b1;
        w_wr_addr = w_rt;
      end
      OP_ORI: begin
        w_alu     = r_a | w_imm_zx;
        w_wr_en   = 1'b1;
        w_wr_addr = w_rt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      case (count_state)
        PH_FETCH: begin
          r_ir <= w_mem;
          r_pc <= r_pc + PCW'(4);
        end
        PH_DECODE: begin
          r_a <= RD1;
          r_b <= RD2;
        end
        PH_EXEC: r_aluout <= w_alu;
        PH_WB: begin
          if (w_wr_en && (w_wr_addr != 5'd0))
            r_rf[w_wr_addr] <= r_aluout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_stepped_core.sv
// Bench for mips_stepped_core: instruction-level model plus directed literal checks.
// Drives phases one per cycle and compares RD1/RD2/Mmemory_output every negedge.
module tb_mips_stepped_core;

  logic        clk;
  logic        reset;
  logic [2:0]  count_state;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] Mmemory_output;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  mips_stepped_core dut (
    .clk(clk),
    .reset(reset),
    .count_state(count_state),
    .RD1(RD1),
    .RD2(RD2),
    .Mmemory_output(Mmemory_output)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Architectural model
  logic [31:0] m_mem [256];
  logic [31:0] m_rf  [32];
  logic [31:0] m_ir, m_a, m_b, m_alu;
  int          m_pc;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input int cs);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic [31:0] imm;
    if (!r) begin
      m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_alu = 0;
      foreach (m_rf[i]) m_rf[i] = 0;
      return;
    end
    op = m_ir[31:26]; fn = m_ir[5:0];
    rs = m_ir[25:21]; rt = m_ir[20:16]; rd = m_ir[15:11];
    imm = {{16{m_ir[15]}}, m_ir[15:0]};
    case (cs)
      1: begin
        m_ir = m_mem[(m_pc / 4) % 256];
        m_pc = m_pc + 4;
      end
      2: begin
        m_a = m_rf[rs];
        m_b = m_rf[rt];
      end
      3: begin
        if (op == 0) begin
          case (fn)
            6'h20: m_alu = m_a + m_b;
            6'h22: m_alu = m_a - m_b;
            6'h24: m_alu = m_a & m_b;
            6'h25: m_alu = m_a | m_b;
            6'h2A: m_alu = ($signed(m_a) < $signed(m_b)) ? 1 : 0;
            6'h00: m_alu = m_b << m_ir[10:6];
            6'h02: m_alu = m_b >> m_ir[10:6];
            default: ;
          endcase
        end else if (op == 6'h08) m_alu = m_a + imm;
        else if (op == 6'h0C) m_alu = m_a & {16'h0, m_ir[15:0]};
        else if (op == 6'h0D) m_alu = m_a | {16'h0, m_ir[15:0]};
      end
      4: begin
        if (op == 0 && fn inside {6'h20, 6'h22, 6'h24, 6'h25,
                                  6'h2A, 6'h00, 6'h02}) begin
          if (rd != 0) m_rf[rd] = m_alu;
        end else if (op inside {6'h08, 6'h0C, 6'h0D}) begin
          if (rt != 0) m_rf[rt] = m_alu;
        end
      end
      default: ;
    endcase
  endtask

  // Single per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd1_model", RD1, m_rf[m_ir[25:21]]);
      check("rd2_model", RD2, m_rf[m_ir[20:16]]);
      check("mem_model", Mmemory_output, m_mem[(m_pc / 4) % 256]);
    end
  end

  task automatic cycle(input bit r, input int cs);
    reset = r;
    count_state = 3'(cs);
    @(posedge clk);
    model_step(r, cs);
    #1;
  endtask

  task automatic fd();
    cycle(1, 1);
    cycle(1, 2);
  endtask

  task automatic ew();
    cycle(1, 3);
    cycle(1, 4);
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = 0;
    m_mem[0] = 32'h2008_0001;
    m_mem[1] = 32'h2009_0002;
    m_mem[2] = 32'h200A_0003;
    m_mem[3] = 32'h200B_00FF;
    m_mem[4] = 32'h218C_0002;
    m_mem[5] = 32'h0128_8820;
    m_mem[6] = 32'h0011_8900;
    m_mem[7] = 32'h022A_8825;
    m_mem[8] = 32'h3173_00F0;
    m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_alu = 0;
    foreach (m_rf[i]) m_rf[i] = 0;

    reset = 0;
    count_state = 0;
    cycle(0, 0);
    cycle(0, 0);
    chk_en = 1;
    check("rst_rd1", RD1, 32'h0);
    check("rst_rd2", RD2, 32'h0);
    check("rst_mem", Mmemory_output, 32'h2008_0001);

    // addi $t0,$zero,1
    fd(); ew();
    check("i1_t0", RD2, 32'h1);
    check("i1_mem", Mmemory_output, 32'h2009_0002);

    // instructions 2-4
    fd(); ew();
    fd(); ew();
    fd(); ew();
    check("i4_t3", RD2, 32'hFF);

    // addi $t4,$t4,2
    fd();
    check("i5_dec_rd1", RD1, 32'h0);
    check("i5_dec_rd2", RD2, 32'h0);
    ew();
    check("i5_t4", RD1, 32'h2);

    // add $s1,$t1,$t0
    fd(); ew();
    check("i6_t1", RD1, 32'h2);
    check("i6_t0", RD2, 32'h1);

    // sll $s1,$s1,4
    fd();
    check("i7_dec_s1", RD2, 32'h3);
    ew();
    check("i7_s1", RD2, 32'h30);

    // or $s1,$s1,$t2
    fd();
    check("i8_dec_rd1", RD1, 32'h30);
    check("i8_dec_rd2", RD2, 32'h3);
    ew();
    check("i8_s1", RD1, 32'h33);

    // idle phases hold state
    repeat (5) cycle(1, 0);
    cycle(1, 5);
    cycle(1, 6);
    cycle(1, 7);
    check("idle_s1", RD1, 32'h33);
    check("idle_mem", Mmemory_output, 32'h3173_00F0);

    // andi $s3,$t3,0xF0
    fd();
    check("i9_dec_t3", RD1, 32'hFF);
    ew();
    check("i9_s3", RD2, 32'hF0);
    check("i9_mem", Mmemory_output, 32'h0);

    // word index wraps back to 0 after 256 fetches in total
    repeat (247) cycle(1, 1);
    check("wrap_mem", Mmemory_output, 32'h2008_0001);
    check("wrap_rd1", RD1, 32'h0);

    // rerun instruction 1, then abort instruction 2 at execute
    fd(); ew();
    fd();
    check("pre_rst_t1", RD2, 32'h2);
    cycle(0, 3);
    check("rst_ex_mem", Mmemory_output, 32'h2008_0001);
    check("rst_ex_rd2", RD2, 32'h0);
    fd();
    check("post_rst_t0", RD2, 32'h0);
    ew();
    check("post_rst_i1", RD2, 32'h1);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
